mem_ctrl_arbiter: RTL and testbench

- Shares the single byte-wide RAM/IO port between instruction fetch (IF) and the load/store buffer (LSB).
- Each requester uses a byte-stream handshake. The requester holds its enable; the controller returns one rdy pulse per byte at consecutive addresses. The requester drops its enable after the last rdy it needs.
- Sits between the IF/LSB units and the top-level RAM interface. Owns arbitration, address sequencing, the IO back-pressure stall, and rollback abort.

---
 rtl/mem_ctrl_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_ctrl_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_arbiter.sv
// Byte-stream arbiter sharing the single RAM/IO port between instruction fetch and the LSB.
// Each byte costs one ISSUE cycle (address/write drive) and one RESP cycle (rdy pulse).
module mem_ctrl_arbiter #(
  parameter int unsigned LSB_BURST_MAX = 4,
  parameter logic [1:0]  IO_ADDR_HI    = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_signal,
  input  logic        if_ena,
  input  logic [31:0] if_addr,
  output logic        if_rdy,
  output logic [7:0]  if_data,
  input  logic        lsb_ena,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [7:0]  lsb_data,
  output logic        lsb_rdy,
  output logic [7:0]  lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned       BurstW   = $clog2(LSB_BURST_MAX + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(LSB_BURST_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIf, OwnLsb} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       offset_q, offset_d;
  logic              wr_q, wr_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [7:0]        if_data_q, if_data_d;
  logic [7:0]        lsb_rdata_q, lsb_rdata_d;

  logic        owner_ena;
  logic        io_stall;
  logic        grant_lsb;
  logic        grant_if;
  logic [31:0] cur_addr;

  assign cur_addr  = base_q + offset_q;
  assign owner_ena = (owner_q == OwnIf)  ? if_ena  :
                     (owner_q == OwnLsb) ? lsb_ena : 1'b0;
  assign io_stall  = wr_q && (cur_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
  // IF is forced in once the LSB has used its burst allowance against a waiting IF.
  assign grant_lsb = lsb_ena && !(if_ena && (burst_q == BurstMax));
  assign grant_if  = !grant_lsb && if_ena;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    offset_d    = offset_q;
    wr_d        = wr_q;
    burst_d     = burst_q;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    mem_a       = '0;
    mem_dout    = '0;
    mem_wr      = 1'b0;
    if_rdy      = 1'b0;
    lsb_rdy     = 1'b0;

    if (!if_ena) burst_d = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_lsb) begin
          owner_d  = OwnLsb;
          base_d   = lsb_addr;
          wr_d     = lsb_wr;
          offset_d = '0;
          burst_d  = if_ena ? burst_q + 1'b1 : '0;
          state_d  = StIssue;
        end else if (grant_if) begin
          owner_d  = OwnIf;
          base_d   = if_addr;
          wr_d     = 1'b0;
          offset_d = '0;
          burst_d  = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (!owner_ena) begin
          state_d = StIdle;
          owner_d = OwnNone;
        end else begin
          mem_a    = cur_addr;
          mem_dout = lsb_data;
          mem_wr   = wr_q;
          if (io_stall) begin
            mem_wr = 1'b0;
          end else begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (owner_q == OwnIf) begin
          if_rdy    = 1'b1;
          if_data_d = mem_din;
        end else if (owner_q == OwnLsb) begin
          lsb_rdy = 1'b1;
          if (!wr_q) lsb_rdata_d = mem_din;
        end
        offset_d = offset_q + 32'd1;
        state_d  = StIssue;
      end
      default: state_d = StIdle;
    endcase

    if (rollback_signal) begin
      state_d     = StIdle;
      owner_d     = OwnNone;
      burst_d     = '0;
      if_data_d   = if_data_q;
      lsb_rdata_d = lsb_rdata_q;
      mem_wr      = 1'b0;
      if_rdy      = 1'b0;
      lsb_rdy     = 1'b0;
    end

    if (!rdy) begin
      mem_wr  = 1'b0;
      if_rdy  = 1'b0;
      lsb_rdy = 1'b0;
    end
  end

  // The byte is presented together with its rdy pulse, then held by the register.
  assign if_data   = if_rdy ? mem_din : if_data_q;
  assign lsb_rdata = (lsb_rdy && !wr_q) ? mem_din : lsb_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      base_q      <= '0;
      offset_q    <= '0;
      wr_q        <= 1'b0;
      burst_q     <= '0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      wr_q        <= wr_d;
      burst_q     <= burst_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Self-checking bench for mem_ctrl_arbiter: directed scenarios plus randomized single-requester
// transactions checked against a byte-addressed RAM reference and transaction-level rules.
module tb_mem_ctrl_arbiter;

  localparam int unsigned RamSize = 1 << 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback_signal;
  logic        if_ena;
  logic [31:0] if_addr;
  logic        if_rdy;
  logic [7:0]  if_data;
  logic        lsb_ena;
  logic        lsb_wr;
  logic [31:0] lsb_addr;
  logic [7:0]  lsb_data;
  logic        lsb_rdy;
  logic [7:0]  lsb_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .rollback_signal (rollback_signal),
    .if_ena          (if_ena),
    .if_addr         (if_addr),
    .if_rdy          (if_rdy),
    .if_data         (if_data),
    .lsb_ena         (lsb_ena),
    .lsb_wr          (lsb_wr),
    .lsb_addr        (lsb_addr),
    .lsb_data        (lsb_data),
    .lsb_rdy         (lsb_rdy),
    .lsb_rdata       (lsb_rdata),
    .mem_din         (mem_din),
    .mem_dout        (mem_dout),
    .mem_a           (mem_a),
    .mem_wr          (mem_wr),
    .io_buffer_full  (io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM model: untouched bytes read a fixed hash of their address.
  logic [7:0] ram     [RamSize];
  bit         written [RamSize];
  logic [7:0] exp_ram [RamSize];
  int         wr_cnt  = 0;
  logic        bd_we   = 1'b0;
  logic [17:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  function automatic logic [7:0] init_byte(input int unsigned a);
    int unsigned h;
    h = a * 32'h9E37_79B1;
    return h[23:16];
  endfunction

  function automatic int unsigned ridx(input logic [31:0] a);
    return int'(a[17:0]);
  endfunction

  function automatic logic [7:0] ram_rd(input int unsigned a);
    return written[a] ? ram[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[17:0]]     <= mem_dout;
      written[mem_a[17:0]] <= 1'b1;
      wr_cnt               <= wr_cnt + 1;
    end
    if (bd_we) begin
      ram[bd_addr]     <= bd_data;
      written[bd_addr] <= 1'b1;
    end
    mem_din <= ram_rd(ridx(mem_a));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input int unsigned a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 18'(a); bd_data = d;
    exp_ram[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // One requester runs a len-byte transaction; chaos adds random freezes and IO back-pressure,
  // timed checks the fixed two-cycle-per-byte cadence from the grant cycle.
  task automatic do_txn(input bit is_if, input bit wr, input logic [31:0] addr, input int len,
                        input logic [7:0] d0, input bit chaos, input bit timed);
    logic [7:0] wdata [4];
    logic       mine, other;
    logic [7:0] rd;
    int         got, iter, w0;
    wdata[0] = d0;
    for (int i = 1; i < 4; i++) wdata[i] = 8'($urandom);
    got = 0; iter = 0; w0 = wr_cnt;
    @(negedge clk);
    if (is_if) begin
      if_ena = 1'b1; if_addr = addr;
    end else begin
      lsb_ena = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_data = wdata[0];
    end
    while (got < len && iter < 200) begin
      @(negedge clk);
      iter++;
      mine  = is_if ? if_rdy : lsb_rdy;
      other = is_if ? lsb_rdy : if_rdy;
      rd    = is_if ? if_data : lsb_rdata;
      check_eq("other_rdy", 32'(other), 32'd0);
      if (timed) begin
        check_eq("rdy_timing", 32'(mine), 32'(iter % 2 == 0));
        if (iter % 2 == 1) begin
          check_eq("mem_a", mem_a, addr + 32'(iter / 2));
          check_eq("mem_wr", 32'(mem_wr), 32'(wr));
          if (wr) check_eq("mem_dout", 32'(mem_dout), 32'(wdata[iter / 2]));
        end
      end
      if (mine) begin
        if (!wr) check_eq("rdata", 32'(rd), 32'(exp_ram[ridx(addr + 32'(got))]));
        got++;
        if (got == len) begin
          if_ena = 1'b0; lsb_ena = 1'b0;
        end else begin
          lsb_data = wdata[got];
        end
      end
      if (chaos) begin
        rdy            = ($urandom_range(4) != 0);
        io_buffer_full = ($urandom_range(2) == 0);
      end
    end
    check_eq("txn_done", 32'(got), 32'(len));
    rdy = 1'b1; io_buffer_full = 1'b0; if_ena = 1'b0; lsb_ena = 1'b0;
    repeat (2) @(negedge clk);
    if (wr) begin
      for (int i = 0; i < len; i++) exp_ram[ridx(addr + 32'(i))] = wdata[i];
      check_eq("wr_count", 32'(wr_cnt - w0), 32'(len));
      for (int i = 0; i <= len; i++)
        check_eq("ram", 32'(ram_rd(ridx(addr + 32'(i)))), 32'(exp_ram[ridx(addr + 32'(i))]));
    end else begin
      check_eq("no_wr", 32'(wr_cnt - w0), 32'd0);
      check_eq("rdata_hold", 32'(is_if ? if_data : lsb_rdata),
               32'(exp_ram[ridx(addr + 32'(len - 1))]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int w0, served, guard, cool_if, cool_lsb, k_if, k_lsb;
    bit is_if, wr;
    logic [31:0] addr;

    rst = 1'b1; rdy = 1'b1; rollback_signal = 1'b0;
    if_ena = 1'b0; if_addr = '0;
    lsb_ena = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_data = 8'h5C;
    io_buffer_full = 1'b0;
    for (int i = 0; i < RamSize; i++) exp_ram[i] = init_byte(i);
    repeat (2) @(negedge clk);
    check_eq("rst_if_rdy", 32'(if_rdy), 32'd0);
    check_eq("rst_lsb_rdy", 32'(lsb_rdy), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_if_data", 32'(if_data), 32'd0);
    check_eq("rst_lsb_rdata", 32'(lsb_rdata), 32'd0);
    preload(32'h100, 8'h11);
    preload(32'h101, 8'h22);
    preload(32'h102, 8'h33);
    preload(32'h103, 8'h44);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_mem_dout", 32'(mem_dout), 32'd0);

    // Directed loads/stores with exact cadence.
    do_txn(1'b0, 1'b0, 32'h100, 4, 8'h00, 1'b0, 1'b1);
    check_eq("load_last", 32'(lsb_rdata), 32'h44);
    do_txn(1'b0, 1'b1, 32'h200, 1, 8'hAB, 1'b0, 1'b1);
    do_txn(1'b1, 1'b0, 32'h1234, 3, 8'h00, 1'b0, 1'b1);
    do_txn(1'b0, 1'b1, 32'h0FFFE, 3, 8'h9D, 1'b0, 1'b1);

    // IO back-pressure stall.
    w0 = wr_cnt;
    @(negedge clk);
    io_buffer_full = 1'b1; lsb_ena = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("io_stall_wr", 32'(mem_wr), 32'd0);
      check_eq("io_stall_rdy", 32'(lsb_rdy), 32'd0);
    end
    io_buffer_full = 1'b0;
    #1;
    check_eq("io_go_wr", 32'(mem_wr), 32'd1);
    check_eq("io_go_a", mem_a, 32'h30000);
    check_eq("io_go_dout", 32'(mem_dout), 32'h5A);
    @(negedge clk);
    check_eq("io_rdy", 32'(lsb_rdy), 32'd1);
    lsb_ena = 1'b0;
    repeat (2) @(negedge clk);
    exp_ram[32'h30000] = 8'h5A;
    check_eq("io_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    check_eq("io_ram", 32'(ram_rd(32'h30000)), 32'h5A);

    // Contention: 1-byte transactions from both sides, LSB burst limit then one IF grant.
    served = 0; guard = 0; cool_if = 0; cool_lsb = 0; k_if = 0; k_lsb = 0;
    lsb_wr = 1'b0;
    while (served < 10 && guard < 300) begin
      check_eq("both_rdy", 32'(if_rdy & lsb_rdy), 32'd0);
      if (if_rdy || lsb_rdy) begin
        check_eq("grant_order", 32'(lsb_rdy), 32'(served % 5 != 4));
        if (lsb_rdy) check_eq("cont_lsb_data", 32'(lsb_rdata), 32'(exp_ram[ridx(lsb_addr)]));
        else         check_eq("cont_if_data", 32'(if_data), 32'(exp_ram[ridx(if_addr)]));
        served++;
      end
      if (lsb_ena && lsb_rdy) begin
        lsb_ena = 1'b0; cool_lsb = 2;
      end else if (!lsb_ena) begin
        if (cool_lsb > 0) cool_lsb--;
        if (cool_lsb == 0) begin
          lsb_ena = 1'b1; lsb_addr = 32'h2000 + 32'(k_lsb); k_lsb++;
        end
      end
      if (if_ena && if_rdy) begin
        if_ena = 1'b0; cool_if = 2;
      end else if (!if_ena) begin
        if (cool_if > 0) cool_if--;
        if (cool_if == 0) begin
          if_ena = 1'b1; if_addr = 32'h1000 + 32'(k_if); k_if++;
        end
      end
      @(negedge clk);
      guard++;
    end
    check_eq("cont_served", 32'(served), 32'd10);
    if_ena = 1'b0; lsb_ena = 1'b0;
    repeat (4) @(negedge clk);

    // Rollback during the RESP of byte 2 of an IF read; a waiting LSB load goes next.
    @(negedge clk);
    if_ena = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rb_first_rdy", 32'(if_rdy), 32'd1);
    check_eq("rb_first_data", 32'(if_data), 32'(exp_ram[0]));
    @(negedge clk);
    @(negedge clk);
    rollback_signal = 1'b1; lsb_ena = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h140;
    #1;
    check_eq("rb_suppress_rdy", 32'(if_rdy), 32'd0);
    @(negedge clk);
    rollback_signal = 1'b0; if_ena = 1'b0;
    check_eq("rb_idle_if_rdy", 32'(if_rdy), 32'd0);
    check_eq("rb_idle_mem_a", mem_a, 32'd0);
    @(negedge clk);
    check_eq("rb_lsb_issue", mem_a, 32'h140);
    @(negedge clk);
    check_eq("rb_lsb_rdy", 32'(lsb_rdy), 32'd1);
    check_eq("rb_lsb_data", 32'(lsb_rdata), 32'(exp_ram[32'h140]));
    check_eq("rb_no_if_rdy", 32'(if_rdy), 32'd0);
    lsb_ena = 1'b0;
    repeat (3) @(negedge clk);

    // Rollback sampled while a store is in ISSUE: no write.
    w0 = wr_cnt;
    @(negedge clk);
    lsb_ena = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h300; lsb_data = 8'hC3;
    @(negedge clk);
    check_eq("rbw_pre_wr", 32'(mem_wr), 32'd1);
    rollback_signal = 1'b1; lsb_ena = 1'b0;
    #1;
    check_eq("rbw_wr_masked", 32'(mem_wr), 32'd0);
    @(negedge clk);
    rollback_signal = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rbw_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    check_eq("rbw_ram", 32'(ram_rd(32'h300)), 32'(exp_ram[32'h300]));

    // Freeze then async reset in the middle of a store.
    w0 = wr_cnt;
    @(negedge clk);
    lsb_ena = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h400; lsb_data = 8'h77;
    @(negedge clk);
    check_eq("frz_pre_wr", 32'(mem_wr), 32'd1);
    rdy = 1'b0;
    #1;
    check_eq("frz_wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
    check_eq("frz_hold_wr", 32'(mem_wr), 32'd0);
    check_eq("frz_hold_rdy", 32'(lsb_rdy), 32'd0);
    rst = 1'b1; lsb_ena = 1'b0;
    #1;
    check_eq("arst_mem_a", mem_a, 32'd0);
    check_eq("arst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("arst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("arst_lsb_rdata", 32'(lsb_rdata), 32'd0);
    check_eq("arst_if_data", 32'(if_data), 32'd0);
    @(negedge clk);
    rdy = 1'b1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post_rst_wr", 32'(mem_wr), 32'd0);
    end
    check_eq("rst_wr_cnt", 32'(wr_cnt - w0), 32'd0);
    check_eq("rst_ram", 32'(ram_rd(32'h400)), 32'(exp_ram[32'h400]));

    // Randomized single-requester traffic with freezes and IO back-pressure.
    for (int t = 0; t < 40; t++) begin
      is_if = 1'($urandom_range(1));
      wr    = !is_if && ($urandom_range(1) == 1);
      addr  = ($urandom_range(3) == 0) ? 32'h30000 + 32'($urandom_range(255))
                                       : 32'($urandom_range(16'hFFFF));
      do_txn(is_if, wr, addr, int'($urandom_range(4, 1)), 8'($urandom), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
